// File: rtl/tdm_mux_pkg.sv
// Shared constants, types and width helper for the TDM multiplexer scanner.
// Used by tdm_scan_ctr and tdm_mux_scanner (optional macro TDM_MUX_MANUAL_SEL_EN lives in the top).
package tdm_mux_pkg;

  localparam int TDM_N_CH_DEF   = 4;
  localparam int TDM_DWELL_DEF  = 16;
  localparam int TDM_DATA_W_DEF = 1;

  typedef enum logic {
    MODE_SCAN   = 1'b0,
    MODE_MANUAL = 1'b1
  } tdm_mode_e;

  // Index width for a 0..n-1 range; never narrower than one bit.
  function automatic int tdm_sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tdm_scan_ctr.sv
// Channel/dwell counter for the TDM scanner: owns ch_q and cnt_q, wraps on explicit
// compares, restarts on sync_start and holds while frozen.
module tdm_scan_ctr
  import tdm_mux_pkg::*;
#(
  parameter int N_CH  = TDM_N_CH_DEF,
  parameter int DWELL = TDM_DWELL_DEF,
  parameter int SEL_W = tdm_sel_w(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             freeze,
  input  logic             sync_start,
  output logic [SEL_W-1:0] ch,
  output logic             slot_first
);

  localparam int               CNT_W    = tdm_sel_w(DWELL);
  localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  logic [SEL_W-1:0] ch_q;
  logic [CNT_W-1:0] cnt_q;

  // sync_start wins over both enable and freeze so a restart is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q  <= '0;
      cnt_q <= '0;
    end else if (sync_start) begin
      ch_q  <= '0;
      cnt_q <= '0;
    end else if (advance && !freeze) begin
      if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        ch_q  <= (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign ch         = ch_q;
  assign slot_first = (ch_q == '0) && (cnt_q == '0);

endmodule

// File: rtl/tdm_mux_scanner.sv
// Time-division multiplexer: scans N_CH channels with DWELL enabled cycles each and
// registers the selected sample with its channel tag. Optional macro: TDM_MUX_MANUAL_SEL_EN.
module tdm_mux_scanner
  import tdm_mux_pkg::*;
#(
  parameter  int N_CH   = TDM_N_CH_DEF,
  parameter  int DATA_W = TDM_DATA_W_DEF,
  parameter  int DWELL  = TDM_DWELL_DEF,
  localparam int SEL_W  = tdm_sel_w(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   sync_start,
  input  logic [N_CH*DATA_W-1:0] din,
  output logic [DATA_W-1:0]      dout,
  output logic [SEL_W-1:0]       dout_ch,
  output logic                   dout_valid,
  output logic                   frame_start
`ifdef TDM_MUX_MANUAL_SEL_EN
  ,
  input  logic                   man_en,
  input  logic [SEL_W-1:0]       man_sel
`endif
);

  logic [SEL_W-1:0]  scan_ch;
  logic [SEL_W-1:0]  sel;
  logic              slot_first;
  logic              freeze;
  tdm_mode_e         mode;
  logic [DATA_W-1:0] sel_data;
  logic              hit;
  logic              smp_fs;

`ifdef TDM_MUX_MANUAL_SEL_EN
  assign mode = man_en ? MODE_MANUAL : MODE_SCAN;
  assign sel  = (mode == MODE_MANUAL) ? man_sel : scan_ch;
`else
  assign mode = MODE_SCAN;
  assign sel  = scan_ch;
`endif

  assign freeze = (mode == MODE_MANUAL);

  tdm_scan_ctr #(
    .N_CH  (N_CH),
    .DWELL (DWELL),
    .SEL_W (SEL_W)
  ) u_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .advance    (en),
    .freeze     (freeze),
    .sync_start (sync_start),
    .ch         (scan_ch),
    .slot_first (slot_first)
  );

  // Compare-based mux: an index outside 0..N_CH-1 yields zero data and no hit.
  always_comb begin
    sel_data = '0;
    hit      = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_data = din[k*DATA_W +: DATA_W];
        hit      = 1'b1;
      end
    end
  end

  assign smp_fs = slot_first && (mode == MODE_SCAN);

  // dout_ch only follows a valid selection so a bad manual index leaves the tag alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout        <= '0;
      dout_ch     <= '0;
      dout_valid  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      dout        <= sel_data;
      dout_valid  <= hit;
      frame_start <= smp_fs;
      if (hit) begin
        dout_ch <= sel;
      end
    end else begin
      dout_valid  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdm_mux_scanner.sv
// Scoreboard bench for tdm_mux_scanner: a 4-channel/dwell-2 and a 3-channel/dwell-1
// instance share stimulus; a frame-position model predicts every cycle's outputs.
module tb_tdm_mux_scanner;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic [1:0] c;
    logic       f;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       sync_start = 1'b0;
  logic       man_en = 1'b0;
  logic [1:0] man_sel = 2'd0;
  bit         hold_reset = 1'b1;
  bit         started = 1'b0;

  logic [7:0] b [4];
  wire  [31:0] din4 = {b[3], b[2], b[1], b[0]};
  wire  [23:0] din3 = {b[2], b[1], b[0]};

  logic [7:0] d0, d1;
  logic [1:0] c0, c1;
  logic       v0, v1, f0, f1;

  int   pos [2];
  logic [7:0] hd [2];
  logic [1:0] hc [2];
  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  tdm_mux_scanner #(.N_CH(4), .DATA_W(8), .DWELL(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .sync_start(sync_start), .din(din4),
    .dout(d0), .dout_ch(c0), .dout_valid(v0), .frame_start(f0)
`ifdef TDM_MUX_MANUAL_SEL_EN
    , .man_en(1'b0), .man_sel(2'd0)
`endif
  );

  tdm_mux_scanner #(.N_CH(3), .DATA_W(8), .DWELL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .sync_start(sync_start), .din(din3),
    .dout(d1), .dout_ch(c1), .dout_valid(v1), .frame_start(f1)
`ifdef TDM_MUX_MANUAL_SEL_EN
    , .man_en(man_en), .man_sel(man_sel)
`endif
  );

  function automatic int n_of(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  function automatic int d_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // The scan is tracked as a position within the frame: channel = pos / DWELL.
  function exp_t model_step(input int i, input logic s_en, input logic s_sync,
                            input logic s_man, input logic [1:0] s_msel);
    exp_t e;
    int   c;
    e = '0;
    if (rst_n !== 1'b1) begin
      pos[i] = 0;
      hd[i]  = 8'h00;
      hc[i]  = 2'd0;
      return e;
    end
    if (s_en) begin
      if (s_man) begin
        if (int'(s_msel) < n_of(i)) begin
          hd[i] = b[s_msel];
          hc[i] = s_msel;
          e.v   = 1'b1;
        end else begin
          hd[i] = 8'h00;
        end
      end else begin
        c      = pos[i] / d_of(i);
        hd[i]  = b[c];
        hc[i]  = 2'(c);
        e.v    = 1'b1;
        e.f    = (pos[i] == 0);
        pos[i] = (pos[i] + 1) % (n_of(i) * d_of(i));
      end
    end
    if (s_sync) pos[i] = 0;
    e.d = hd[i];
    e.c = hc[i];
    return e;
  endfunction

  task automatic checkOutput(input int i, input exp_t e);
    exp_t a;
    a = (i == 0) ? {v0, d0, c0, f0} : {v1, d1, c1, f1};
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("[TB] FAIL out%0d t=%0t got v=%b d=%h ch=%0d fs=%b, expected v=%b d=%h ch=%0d fs=%b",
               i, $time, a.v, a.d, a.c, a.f, e.v, e.d, e.c, e.f);
    end
  endtask

  task automatic applyStimulus(input logic a_en, input logic a_sync, input logic a_man,
                               input logic [1:0] a_msel, input bit rnd);
    @(negedge clk);
    rst_n      = ~hold_reset;
    en         = a_en;
    sync_start = a_sync;
    man_en     = a_man;
    man_sel    = a_msel;
    if (rnd) begin
      for (int k = 0; k < 4; k++) b[k] = 8'($urandom);
    end
    started = 1'b1;
    q0.push_back(model_step(0, a_en, a_sync, 1'b0, 2'd0));
    q1.push_back(model_step(1, a_en, a_sync, a_man, a_msel));
  endtask

  task automatic resetMidSlot();
    @(posedge clk);
    #3;
    hold_reset = 1'b1;
    rst_n      = 1'b0;
    #1;
    checkOutput(0, exp_t'(0));
    checkOutput(1, exp_t'(0));
  endtask

  always @(posedge clk) begin
    #1;
    if (started) begin
      if (q0.size() == 0 || q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL scoreboard t=%0t got empty queue, expected a pending sample", $time);
      end else begin
        checkOutput(0, q0.pop_front());
        checkOutput(1, q1.pop_front());
      end
    end
  end

  initial begin
    logic       r_en, r_sync, r_man;
    logic [1:0] r_sel;
    b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44;
    #1 rst_n = 1'b0;
    #1;
    checkOutput(0, exp_t'(0));
    checkOutput(1, exp_t'(0));
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    hold_reset = 1'b0;

    // Fixed-pattern scan: two full frames on the 4-channel instance.
    repeat (16) applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);

    // Stall mid-slot on channel 2, then let it finish its dwell.
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);

    // Restart while on channel 3, cycle 1.
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);

    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
    resetMidSlot();
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
    hold_reset = 1'b0;
    repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);

`ifdef TDM_MUX_MANUAL_SEL_EN
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, 2'd2, 1'b1);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, 2'd3, 1'b1);
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
`endif

    for (int n = 0; n < 400; n++) begin
      r_en   = ($urandom_range(0, 3) != 0);
      r_sync = ($urandom_range(0, 19) == 0);
      r_sel  = 2'($urandom_range(0, 3));
`ifdef TDM_MUX_MANUAL_SEL_EN
      r_man  = ($urandom_range(0, 3) == 0);
`else
      r_man  = 1'b0;
`endif
      applyStimulus(r_en, r_sync, r_man, r_sel, 1'b1);
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
